pipelined_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter; next generation of the 4-bit combinational shift-left.

---
 rtl/pipelined_shifter_pkg.sv | 38 +++
 rtl/pipelined_shifter_if.sv | 30 +++
 rtl/pipelined_shifter_stage.sv | 65 ++++++
 rtl/pipelined_shifter.sv | 70 +++++++
 tb/tb_pipelined_shifter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_shifter_pkg.sv
// Shared types and the single-stage shift helper for the pipelined barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_e;

  // Widest operand the helper supports; stages zero-extend into this width.
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_IDX_W = 6;

  // Shift the low w bits of data by 2**k in the given mode; bits above w are returned as 0.
  function automatic logic [MAX_W-1:0] shift_by_pow2(input logic [MAX_W-1:0] data,
                                                     input shift_mode_e      mode,
                                                     input int unsigned      k,
                                                     input int unsigned      w);
    logic [MAX_W-1:0] res;
    int unsigned      s;
    s   = 32'(1) << k;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        unique case (mode)
          SH_SLL: res[MAX_IDX_W'(i)] = (i >= s) ? data[MAX_IDX_W'(i - s)] : 1'b0;
          SH_SRL: res[MAX_IDX_W'(i)] = (i + s < w) ? data[MAX_IDX_W'(i + s)] : 1'b0;
          SH_SRA: res[MAX_IDX_W'(i)] = (i + s < w) ? data[MAX_IDX_W'(i + s)]
                                                    : data[MAX_IDX_W'(w - 1)];
          SH_ROL: res[MAX_IDX_W'(i)] = data[MAX_IDX_W'((i + w - s) % w)];
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle between capture logic, the shifter and the display path.
interface pipelined_shifter_if
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  shift_mode_e        in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_overflow;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_zero
  );

endinterface

// File: rtl/pipelined_shifter_stage.sv
// One registered barrel-shifter stage: resolves shift-amount bit K and accumulates SLL overflow.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 0,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  shift_mode_e        in_mode,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_ovf,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output shift_mode_e        out_mode,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_ovf,
  output logic [WIDTH-1:0]   nxt_data_c
);

  localparam int unsigned SH = 32'(1) << K;

  logic [MAX_W-1:0] shifted_c;
  logic             lost_c;
  logic             nxt_ovf_c;

  assign shifted_c = shift_by_pow2(MAX_W'(in_data), in_mode, K, WIDTH);

  // Upper helper bits are always zero for narrower operands.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |shifted_c[MAX_W-1:WIDTH];
  end

  always_comb begin
    nxt_data_c = in_data;
    lost_c     = |in_data[WIDTH-1 -: SH];
    nxt_ovf_c  = in_ovf;
    if (in_shamt[K]) begin
      nxt_data_c = shifted_c[WIDTH-1:0];
      nxt_ovf_c  = in_ovf | ((in_mode == SH_SLL) && lost_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= SH_SLL;
      out_shamt <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= nxt_data_c;
      out_mode  <= in_mode;
      out_shamt <= in_shamt;
      out_ovf   <= nxt_ovf_c;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) lock-step stages under a single global advance enable.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_shifter_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned STAGES  = SHAMT_W;

  logic               adv_c;
  logic               zero_q;
  logic               valid_q [STAGES+1];
  logic [WIDTH-1:0]   data_q  [STAGES+1];
  shift_mode_e        mode_q  [STAGES+1];
  logic [SHAMT_W-1:0] shamt_q [STAGES+1];
  logic               ovf_q   [STAGES+1];
  logic [WIDTH-1:0]   nxt_data_c [STAGES];

  // Whole pipe moves together unless a valid result is being held back.
  assign adv_c        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv_c;

  assign valid_q[0] = bus.in_valid;
  assign data_q[0]  = bus.in_data;
  assign mode_q[0]  = bus.in_mode;
  assign shamt_q[0] = bus.in_shamt;
  assign ovf_q[0]   = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv_c),
      .in_valid   (valid_q[k]),
      .in_data    (data_q[k]),
      .in_mode    (mode_q[k]),
      .in_shamt   (shamt_q[k]),
      .in_ovf     (ovf_q[k]),
      .out_valid  (valid_q[k+1]),
      .out_data   (data_q[k+1]),
      .out_mode   (mode_q[k+1]),
      .out_shamt  (shamt_q[k+1]),
      .out_ovf    (ovf_q[k+1]),
      .nxt_data_c (nxt_data_c[k])
    );
  end

  // Zero flag is captured alongside the final data rather than decoded from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (adv_c) begin
      zero_q <= (nxt_data_c[STAGES-1] == '0);
    end
  end

  assign bus.out_valid    = valid_q[STAGES];
  assign bus.out_data     = data_q[STAGES];
  assign bus.out_overflow = ovf_q[STAGES];
  assign bus.out_zero     = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for the pipelined shifter at WIDTH 8, 16 and 2.
module tb_pipelined_shifter;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(8))  bus8();
  pipelined_shifter_if #(.WIDTH(16)) bus16();
  pipelined_shifter_if #(.WIDTH(2))  bus2();

  pipelined_shifter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_shifter #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipelined_shifter #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v, input logic [15:0] d,
                       input int unsigned s, input shift_mode_e m);
    case (w)
      8: begin
        bus8.in_valid = v; bus8.in_data = d[7:0]; bus8.in_shamt = 3'(s); bus8.in_mode = m;
      end
      16: begin
        bus16.in_valid = v; bus16.in_data = d; bus16.in_shamt = 4'(s); bus16.in_mode = m;
      end
      default: begin
        bus2.in_valid = v; bus2.in_data = d[1:0]; bus2.in_shamt = 1'(s); bus2.in_mode = m;
      end
    endcase
  endtask

  function automatic logic o_valid(input int w);
    case (w)
      8:       return bus8.out_valid;
      16:      return bus16.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  function automatic logic o_ready(input int w);
    case (w)
      8:       return bus8.in_ready;
      16:      return bus16.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  function automatic logic [15:0] o_data(input int w);
    case (w)
      8:       return 16'(bus8.out_data);
      16:      return bus16.out_data;
      default: return 16'(bus2.out_data);
    endcase
  endfunction

  function automatic logic [1:0] o_flags(input int w);
    case (w)
      8:       return {bus8.out_overflow, bus8.out_zero};
      16:      return {bus16.out_overflow, bus16.out_zero};
      default: return {bus2.out_overflow, bus2.out_zero};
    endcase
  endfunction

  // Independent 8-bit reference: returns {overflow, data}.
  function automatic logic [8:0] ref8(input logic [7:0] d, input int unsigned s, input shift_mode_e m);
    logic [15:0] f;
    case (m)
      SH_SLL: begin f = {8'h00, d} << s; return {|f[15:8], f[7:0]}; end
      SH_SRL: return {1'b0, d >> s};
      SH_SRA: return {1'b0, 8'($signed(d) >>> s)};
      default: begin f = {d, d} << s; return {1'b0, f[15:8]}; end
    endcase
  endfunction

  // Single operation with an idle pipe: checks accept, latency and result.
  task automatic run_op(input int w, input int lat, input logic [15:0] d, input int unsigned s,
                        input shift_mode_e m, input logic [15:0] ed, input logic eo,
                        input logic ez, input string tag);
    int n;
    n = 0;
    drive(w, 1'b1, d, s, m);
    #1;
    check({tag, "/in_ready"}, 16'(o_ready(w)), 16'd1);
    do begin
      tick();
      n++;
      if (n == 1) drive(w, 1'b0, d, s, m);
      #1;
    end while (!o_valid(w) && n < 12);
    check({tag, "/latency"}, 16'(n), 16'(lat));
    check({tag, "/data"}, o_data(w), ed);
    check({tag, "/ovf_zero"}, 16'(o_flags(w)), 16'({eo, ez}));
    tick();
  endtask

  logic [7:0]  q_d[$];
  logic        q_o[$];
  logic [7:0]  rd;
  int unsigned rs;
  shift_mode_e rm;
  logic [8:0]  rr;
  logic [7:0]  ed;
  logic        eo;
  int          sent, got, cyc;
  logic        stale;

  initial begin
    drive(8, 1'b0, 16'h0, 0, SH_SLL);
    drive(16, 1'b0, 16'h0, 0, SH_SLL);
    drive(2, 1'b0, 16'h0, 0, SH_SLL);
    bus8.out_ready = 1'b1; bus16.out_ready = 1'b1; bus2.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst/out_valid", 16'(bus8.out_valid), 16'd0);
    check("rst/out_data", o_data(8), 16'h0);
    check("rst/ovf_zero", 16'(o_flags(8)), 16'd0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst/in_ready", 16'(bus8.in_ready), 16'd1);

    // Directed WIDTH=8 vectors
    run_op(8, 3, 16'h0B, 2, SH_SLL, 16'h2C, 1'b0, 1'b0, "w8_sll_0b_2");
    run_op(8, 3, 16'hC1, 3, SH_SLL, 16'h08, 1'b1, 1'b0, "w8_sll_c1_3");
    run_op(8, 3, 16'h90, 4, SH_SRA, 16'hF9, 1'b0, 1'b0, "w8_sra_90_4");
    run_op(8, 3, 16'h90, 4, SH_SRL, 16'h09, 1'b0, 1'b0, "w8_srl_90_4");
    run_op(8, 3, 16'h81, 1, SH_ROL, 16'h03, 1'b0, 1'b0, "w8_rol_81_1");
    run_op(8, 3, 16'h80, 1, SH_SLL, 16'h00, 1'b1, 1'b1, "w8_sll_80_1");
    run_op(8, 3, 16'h96, 7, SH_ROL, 16'h4B, 1'b0, 1'b0, "w8_rol_96_7");
    run_op(8, 3, 16'h7F, 7, SH_SRA, 16'h00, 1'b0, 1'b1, "w8_sra_7f_7");
    run_op(8, 3, 16'hFF, 7, SH_SRL, 16'h01, 1'b0, 1'b0, "w8_srl_ff_7");
    for (int i = 0; i < 4; i++)
      run_op(8, 3, 16'hA5, 0, shift_mode_e'(i), 16'hA5, 1'b0, 1'b0, "w8_shamt0");

    // Random stream with random backpressure against the reference model
    sent = 0; got = 0; cyc = 0;
    while (got < 16 && cyc < 400) begin
      tick();
      cyc++;
      rd = 8'($urandom);
      rs = $urandom_range(0, 7);
      rm = shift_mode_e'($urandom_range(0, 3));
      drive(8, (sent < 16) && ($urandom_range(0, 3) != 0), 16'(rd), rs, rm);
      bus8.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus8.out_valid && !bus8.out_ready)
        check("stream/in_ready_stall", 16'(bus8.in_ready), 16'd0);
      if (bus8.out_valid && bus8.out_ready) begin
        if (q_d.size() == 0) begin
          check("stream/unexpected_result", 16'd1, 16'd0);
        end else begin
          ed = q_d.pop_front();
          eo = q_o.pop_front();
          check("stream/data", o_data(8), 16'(ed));
          check("stream/ovf_zero", 16'(o_flags(8)), 16'({eo, ed == 8'h00}));
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        rr = ref8(rd, rs, rm);
        q_d.push_back(rr[7:0]);
        q_o.push_back(rr[8]);
        sent++;
      end
    end
    check("stream/results", 16'(got), 16'd16);
    check("stream/leftover", 16'(q_d.size()), 16'd0);
    drive(8, 1'b0, 16'h0, 0, SH_SLL);
    bus8.out_ready = 1'b1;
    tick(); tick(); tick(); tick();

    // Fill and stall the pipe, then reset it mid-flight
    bus8.out_ready = 1'b0;
    drive(8, 1'b1, 16'hC1, 3, SH_SLL); tick();
    drive(8, 1'b1, 16'h0B, 2, SH_SLL); tick();
    drive(8, 1'b1, 16'h90, 4, SH_SRA); tick();
    drive(8, 1'b0, 16'h0, 0, SH_SLL); tick(); tick();
    #1;
    check("stall/out_valid", 16'(bus8.out_valid), 16'd1);
    check("stall/out_data", o_data(8), 16'h08);
    check("stall/ovf_zero", 16'(o_flags(8)), 16'b10);
    check("stall/in_ready", 16'(bus8.in_ready), 16'd0);
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 16'(bus8.out_valid), 16'd0);
    check("midrst/out_data", o_data(8), 16'h0);
    check("midrst/ovf_zero", 16'(o_flags(8)), 16'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus8.out_valid) stale = 1'b1;
    end
    check("midrst/no_stale", 16'(stale), 16'd0);
    check("midrst/in_ready", 16'(bus8.in_ready), 16'd1);

    // WIDTH=16
    run_op(16, 4, 16'h000B, 2, SH_SLL, 16'h002C, 1'b0, 1'b0, "w16_sll_000b_2");
    run_op(16, 4, 16'hC001, 3, SH_SLL, 16'h0008, 1'b1, 1'b0, "w16_sll_c001_3");
    run_op(16, 4, 16'h9000, 4, SH_SRA, 16'hF900, 1'b0, 1'b0, "w16_sra_9000_4");
    run_op(16, 4, 16'h9000, 4, SH_SRL, 16'h0900, 1'b0, 1'b0, "w16_srl_9000_4");
    run_op(16, 4, 16'h8001, 1, SH_ROL, 16'h0003, 1'b0, 1'b0, "w16_rol_8001_1");
    run_op(16, 4, 16'h8000, 1, SH_SLL, 16'h0000, 1'b1, 1'b1, "w16_sll_8000_1");

    // WIDTH=2
    run_op(2, 1, 16'h1, 1, SH_SLL, 16'h2, 1'b0, 1'b0, "w2_sll_01_1");
    run_op(2, 1, 16'h3, 1, SH_SLL, 16'h2, 1'b1, 1'b0, "w2_sll_11_1");
    run_op(2, 1, 16'h2, 1, SH_SRA, 16'h3, 1'b0, 1'b0, "w2_sra_10_1");
    run_op(2, 1, 16'h2, 1, SH_SRL, 16'h1, 1'b0, 1'b0, "w2_srl_10_1");
    run_op(2, 1, 16'h2, 1, SH_ROL, 16'h1, 1'b0, 1'b0, "w2_rol_10_1");
    run_op(2, 1, 16'h2, 1, SH_SLL, 16'h0, 1'b1, 1'b1, "w2_sll_10_1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
